// File: rtl/hazard_ctrl_unit.sv
// Hazard control unit for the 5-stage RV32I pipeline.
// It produces the E-stage operand forwarding selects, the load-use interlock,
// branch flushes, a wait/timeout FSM for the multi-cycle MUL/DIV unit,
// data-memory wait-state stalls, and saturating stall/flush event counters.
module hazard_ctrl_unit #(
    parameter int AW     = 5,
    parameter int CNT_W  = 32,
    parameter int MC_MAX = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reg_wrE,
    input  logic             reg_wrM,
    input  logic             reg_wrW,
    input  logic [1:0]       wb_selE,
    input  logic [AW-1:0]    raddr1D,
    input  logic [AW-1:0]    raddr2D,
    input  logic [AW-1:0]    raddr1E,
    input  logic [AW-1:0]    raddr2E,
    input  logic [AW-1:0]    waddrE,
    input  logic [AW-1:0]    waddrM,
    input  logic [AW-1:0]    waddrW,
    input  logic             br_takenE,
    input  logic             mc_startE,
    input  logic             mc_done,
    input  logic             dmem_reqM,
    input  logic             dmem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int              MCW     = (MC_MAX > 1) ? $clog2(MC_MAX) : 1;
    localparam logic [MCW-1:0]  MC_LAST = MCW'(MC_MAX - 1);

    localparam logic [1:0] FWD_M  = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b10;
    localparam logic [1:0] FWD_RF = 2'b01;
    localparam logic [1:0] WB_LOAD = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MC_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [MCW-1:0]     mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]   flush_count_q, flush_count_d;

    logic       mem_wait;
    logic       mc_wait;
    logic       mc_expire;
    logic       load_use;
    logic       br_flush;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_m;
    logic [1:0] fwd_a, fwd_b;

    // Pick the newest producer of an E-stage source; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] raddr);
        logic valid;
        valid = (raddr != '0);
        if (valid && reg_wrM && (raddr == waddrM)) begin
            return FWD_M;
        end else if (valid && reg_wrW && (raddr == waddrW)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    // Hazard detection and prioritised stall/flush generation.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves a latch behind.
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        br_flush = 1'b0;

        fwd_a = fwd_sel(raddr1E);
        fwd_b = fwd_sel(raddr2E);

        mem_wait  = dmem_reqM & ~dmem_ready;
        mc_expire = (state_q == MC_WAIT) & ~mc_done & (mc_cnt_q == MC_LAST);
        mc_wait   = ((state_q == MC_WAIT) & ~mc_done & ~mc_expire)
                  | ((state_q == RUN) & mc_startE & ~mc_done);
        load_use  = (wb_selE == WB_LOAD) & reg_wrE & (waddrE != '0)
                  & ((raddr1D == waddrE) | (raddr2D == waddrE));

        if (mem_wait) begin
            // Freeze the whole front end; a branch in E resolves again later.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (mc_wait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (br_takenE) begin
            // Wrong-path D instruction is squashed, so a load-use on it is moot.
            flush_d  = 1'b1;
            flush_e  = 1'b1;
            br_flush = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    // FSM next state, multi-cycle watchdog and saturating event counters.
    always_comb begin
        state_d        = state_q;
        mc_cnt_d       = mc_cnt_q;
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;

        unique case (state_q)
            RUN: begin
                if (mem_wait) begin
                    state_d = MEM_WAIT;
                end else if (mc_startE && !mc_done) begin
                    state_d  = MC_WAIT;
                    mc_cnt_d = MCW'(1);
                end
            end
            MC_WAIT: begin
                if (mc_done || mc_expire) begin
                    state_d  = RUN;
                    mc_cnt_d = '0;
                end else begin
                    mc_cnt_d = mc_cnt_q + MCW'(1);
                end
            end
            MEM_WAIT: begin
                // A withdrawn request also ends the wait so the FSM cannot stick.
                if (dmem_ready || !dmem_reqM) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d  = RUN;
                mc_cnt_d = '0;
            end
        endcase

        if (stall_f && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (br_flush && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            mc_cnt_q       <= '0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            state_q        <= state_d;
            mc_cnt_q       <= mc_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    // NOTE: control outputs are gated by rst_n so they drop asynchronously, not at the next edge.
    assign StallF       = rst_n & stall_f;
    assign StallD       = rst_n & stall_d;
    assign StallE       = rst_n & stall_e;
    assign StallM       = rst_n & stall_m;
    assign FlushD       = rst_n & flush_d;
    assign FlushE       = rst_n & flush_e;
    assign FlushM       = rst_n & flush_m;
    assign forwardAE    = rst_n ? fwd_a : FWD_RF;
    assign forwardBE    = rst_n ? fwd_b : FWD_RF;
    assign mc_timeout   = rst_n & mc_expire;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: a full-size instance and a small
// one (3-bit counters, 4-cycle MC limit) share all inputs and are compared each
// cycle against a behavioural model, after a set of directed scenarios.
module tb_hazard_ctrl_unit;

    localparam int AW = 5;

    logic clk, rst_n;
    logic reg_wrE, reg_wrM, reg_wrW;
    logic [1:0] wb_selE;
    logic [AW-1:0] raddr1D, raddr2D, raddr1E, raddr2E, waddrE, waddrM, waddrW;
    logic br_takenE, mc_startE, mc_done, dmem_reqM, dmem_ready;

    logic sf_a, sd_a, se_a, sm_a, fd_a, fe_a, fm_a, tmo_a;
    logic [1:0] fa_a, fb_a;
    logic [31:0] sc_a, fc_a;
    logic sf_s, sd_s, se_s, sm_s, fd_s, fe_s, fm_s, tmo_s;
    logic [1:0] fa_s, fb_s;
    logic [2:0] sc_s, fc_s;

    hazard_ctrl_unit #(.AW(AW), .CNT_W(32), .MC_MAX(34)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .reg_wrE(reg_wrE), .reg_wrM(reg_wrM), .reg_wrW(reg_wrW), .wb_selE(wb_selE),
        .raddr1D(raddr1D), .raddr2D(raddr2D), .raddr1E(raddr1E), .raddr2E(raddr2E),
        .waddrE(waddrE), .waddrM(waddrM), .waddrW(waddrW),
        .br_takenE(br_takenE), .mc_startE(mc_startE), .mc_done(mc_done),
        .dmem_reqM(dmem_reqM), .dmem_ready(dmem_ready),
        .StallF(sf_a), .StallD(sd_a), .StallE(se_a), .StallM(sm_a),
        .FlushD(fd_a), .FlushE(fe_a), .FlushM(fm_a),
        .forwardAE(fa_a), .forwardBE(fb_a), .mc_timeout(tmo_a),
        .stall_cycles(sc_a), .flush_count(fc_a)
    );

    hazard_ctrl_unit #(.AW(AW), .CNT_W(3), .MC_MAX(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .reg_wrE(reg_wrE), .reg_wrM(reg_wrM), .reg_wrW(reg_wrW), .wb_selE(wb_selE),
        .raddr1D(raddr1D), .raddr2D(raddr2D), .raddr1E(raddr1E), .raddr2E(raddr2E),
        .waddrE(waddrE), .waddrM(waddrM), .waddrW(waddrW),
        .br_takenE(br_takenE), .mc_startE(mc_startE), .mc_done(mc_done),
        .dmem_reqM(dmem_reqM), .dmem_ready(dmem_ready),
        .StallF(sf_s), .StallD(sd_s), .StallE(se_s), .StallM(sm_s),
        .FlushD(fd_s), .FlushE(fe_s), .FlushM(fm_s),
        .forwardAE(fa_s), .forwardBE(fb_s), .mc_timeout(tmo_s),
        .stall_cycles(sc_s), .flush_count(fc_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Index 0 models dut_a, index 1 models dut_s.
    int     mc_limit[2]  = '{34, 4};
    longint cnt_limit[2] = '{64'hFFFF_FFFF, 64'd7};
    bit     mc_busy[2];     // waiting for the multi-cycle unit
    bit     mem_busy[2];    // a memory wait was seen and has not completed
    int     mc_age[2];      // cycles spent on the current multi-cycle op
    longint stalls[2];
    longint flushes[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mc_busy[i] = 0; mem_busy[i] = 0; mc_age[i] = 0;
            stalls[i] = 0; flushes[i] = 0;
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [AW-1:0] ra);
        if (ra == 0) return 2'b01;
        if (reg_wrM && ra == waddrM) return 2'b00;
        if (reg_wrW && ra == waddrW) return 2'b10;
        return 2'b01;
    endfunction

    // Check one cycle of both DUTs against the model, then advance a clock.
    task automatic run_cycle();
        bit mem_w, expire, mc_w, lu, brf;
        logic [6:0] exp_ctl, obs_ctl;
        logic [1:0] ofa, ofb;
        logic otmo;
        longint osc, ofc;
        #1;
        for (int i = 0; i < 2; i++) begin
            mem_w  = dmem_reqM && !dmem_ready;
            expire = mc_busy[i] && !mc_done && (mc_age[i] == mc_limit[i] - 1);
            mc_w   = mc_busy[i] ? (!mc_done && !expire)
                                : (!mem_busy[i] && mc_startE && !mc_done);
            lu     = (wb_selE == 2'b10) && reg_wrE && (waddrE != 0)
                     && (raddr1D == waddrE || raddr2D == waddrE);
            brf    = 0;
            // order: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM}
            if (mem_w)          exp_ctl = 7'b1111_000;
            else if (mc_w)      exp_ctl = 7'b1110_001;
            else if (br_takenE) begin exp_ctl = 7'b0000_110; brf = 1; end
            else if (lu)        exp_ctl = 7'b1100_010;
            else                exp_ctl = 7'b0000_000;

            if (i == 0) begin
                obs_ctl = {sf_a, sd_a, se_a, sm_a, fd_a, fe_a, fm_a};
                ofa = fa_a; ofb = fb_a; otmo = tmo_a; osc = sc_a; ofc = fc_a;
            end else begin
                obs_ctl = {sf_s, sd_s, se_s, sm_s, fd_s, fe_s, fm_s};
                ofa = fa_s; ofb = fb_s; otmo = tmo_s; osc = sc_s; ofc = fc_s;
            end
            check($sformatf("ctl[%0d]", i), obs_ctl, exp_ctl);
            check($sformatf("fwdA[%0d]", i), ofa, fwd_ref(raddr1E));
            check($sformatf("fwdB[%0d]", i), ofb, fwd_ref(raddr2E));
            check($sformatf("timeout[%0d]", i), otmo, expire);
            check($sformatf("stall_cycles[%0d]", i), osc, stalls[i]);
            check($sformatf("flush_count[%0d]", i), ofc, flushes[i]);

            // advance the model to what the next edge will produce
            if (exp_ctl[6] && stalls[i] < cnt_limit[i]) stalls[i]++;
            if (brf && flushes[i] < cnt_limit[i]) flushes[i]++;
            if (mc_busy[i]) begin
                if (mc_done || expire) begin mc_busy[i] = 0; mc_age[i] = 0; end
                else mc_age[i]++;
            end else if (mem_busy[i]) begin
                if (dmem_ready || !dmem_reqM) mem_busy[i] = 0;
            end else if (mem_w) begin
                mem_busy[i] = 1;
            end else if (mc_startE && !mc_done) begin
                mc_busy[i] = 1; mc_age[i] = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        reg_wrE = 0; reg_wrM = 0; reg_wrW = 0; wb_selE = 2'b00;
        raddr1D = 0; raddr2D = 0; raddr1E = 0; raddr2E = 0;
        waddrE = 0; waddrM = 0; waddrW = 0;
        br_takenE = 0; mc_startE = 0; mc_done = 0; dmem_reqM = 0; dmem_ready = 0;
    endtask

    task automatic load_use_inputs(input logic [AW-1:0] rd);
        wb_selE = 2'b10; reg_wrE = 1; waddrE = rd; raddr2D = 7;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        // Reset forces controls idle and forwarding to the register file.
        idle();
        rst_n = 0;
        raddr1E = 5; waddrM = 5; reg_wrM = 1; dmem_reqM = 1; mc_startE = 1;
        #2;
        check("rst_fwdA", fa_a, 2'b01);
        check("rst_stallF", sf_a, 1'b0);
        check("rst_stallM_s", sm_s, 1'b0);
        check("rst_flushM", fm_a, 1'b0);
        check("rst_cnt", sc_a, 32'd0);
        @(negedge clk);
        idle();
        model_reset();
        rst_n = 1;

        // Forwarding priority M > W > register file.
        raddr1E = 5; waddrM = 5; reg_wrM = 1; waddrW = 5; reg_wrW = 1;
        #1 check("fwd_M", fa_a, 2'b00);
        run_cycle();
        reg_wrM = 0;
        #1 check("fwd_W", fa_a, 2'b10);
        run_cycle();
        raddr1E = 0;
        #1 check("fwd_x0", fa_a, 2'b01);
        run_cycle();

        // Load-use interlock, and its x0 exception.
        idle(); load_use_inputs(7);
        #1 check("lu_ctl", {sf_a, sd_a, fe_a}, 3'b111);
        run_cycle();
        idle();
        #1 check("lu_count", sc_a, 32'd1);
        run_cycle();
        load_use_inputs(0);
        #1 check("lu_x0", sf_a, 1'b0);
        run_cycle();

        // Branch overrides a simultaneous load-use.
        idle(); load_use_inputs(7); br_takenE = 1;
        #1 check("br_lu", {fd_a, fe_a, sf_a}, 3'b110);
        run_cycle();
        idle();
        #1 check("br_count", fc_a, 32'd1);
        run_cycle();

        // Multi-cycle op finishing on its 5th cycle (dut_s times out on its 4th).
        for (int c = 1; c <= 5; c++) begin
            idle(); mc_startE = 1; mc_done = (c == 5);
            #1 check($sformatf("mc_stall_c%0d", c), {sf_a, sd_a, se_a, fm_a}, (c < 5) ? 4'b1111 : 4'b0000);
            run_cycle();
        end
        // Timeout on the small instance; the large one is released by a late done.
        for (int c = 1; c <= 5; c++) begin
            idle(); mc_startE = (c < 5); mc_done = (c == 5);
            #1;
            if (c == 4) begin
                check("mc_timeout", tmo_s, 1'b1);
                check("mc_timeout_drop", sf_s, 1'b0);
            end
            run_cycle();
        end
        idle();
        run_cycle();

        // Memory wait holds a taken branch; the flush lands on the ready cycle.
        for (int c = 1; c <= 4; c++) begin
            idle(); br_takenE = 1; dmem_reqM = 1; dmem_ready = (c == 4);
            #1;
            if (c < 4) check($sformatf("mem_hold_c%0d", c), {sf_a, sd_a, se_a, sm_a, fd_a, fe_a}, 6'b111100);
            else       check("mem_release", {sm_a, fd_a, fe_a}, 3'b011);
            run_cycle();
        end

        // Counter saturation on the 3-bit instance.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            idle(); dmem_reqM = 1;
            run_cycle();
        end
        idle();
        #1;
        check("sat_small", sc_s, 3'd7);
        check("sat_large", sc_a, 32'd10);
        run_cycle();

        // Asynchronous reset in the middle of an MC wait.
        idle(); mc_startE = 1;
        run_cycle();
        run_cycle();
        #2 rst_n = 0;
        #1;
        check("rst_mid_stall", {sf_a, sd_a, se_a, fm_a}, 4'b0000);
        check("rst_mid_cnt", sc_a, 32'd0);
        check("rst_mid_cnt_s", sc_s, 3'd0);
        idle();
        model_reset();
        @(negedge clk);
        rst_n = 1;

        // Randomised traffic with small address ranges to force collisions.
        for (int n = 0; n < 3000; n++) begin
            reg_wrE = ($urandom_range(0, 3) != 0);
            reg_wrM = $urandom_range(0, 1);
            reg_wrW = $urandom_range(0, 1);
            wb_selE = 2'($urandom_range(0, 3));
            raddr1D = AW'($urandom_range(0, 3)); raddr2D = AW'($urandom_range(0, 3));
            raddr1E = AW'($urandom_range(0, 3)); raddr2E = AW'($urandom_range(0, 3));
            waddrE  = AW'($urandom_range(0, 3)); waddrM  = AW'($urandom_range(0, 3));
            waddrW  = AW'($urandom_range(0, 3));
            br_takenE  = ($urandom_range(0, 4) == 0);
            mc_startE  = ($urandom_range(0, 2) == 0);
            mc_done    = ($urandom_range(0, 7) == 0);
            dmem_reqM  = ($urandom_range(0, 2) == 0);
            dmem_ready = $urandom_range(0, 1);
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Next-generation hazard unit for the 5-stage RV32I pipeline.
- Keeps the existing M/W operand-forwarding encoding and the load-use interlock, with register-address width parametrised.
- Adds:
  - branch flush control;
  - a multi-cycle execute-unit (MUL/DIV) wait FSM with timeout;
  - data-memory wait-state stalling;
  - saturating stall/flush performance counters.
- Sits beside the datapath; drives per-stage stall/flush enables and the E-stage operand mux selects.

Parameters:
AW, 5, register address width
CNT_W, 32, width of performance counters
MC_MAX, 34, max cycles to wait for mc_done before timeout (>=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
reg_wrE, reg_wrM, reg_wrW  in  1 each  register write enable of instruction in E/M/W
wb_selE  in  2  writeback select of instruction in E; 2'b10 = load
raddr1D, raddr2D, raddr1E, raddr2E  in  AW each  source register addresses in D/E
waddrE, waddrM, waddrW  in  AW each  destination addresses in E/M/W
br_takenE  in  1  branch/jump resolved taken in E
mc_startE  in  1  multi-cycle op occupies E
mc_done  in  1  multi-cycle unit result valid (1-cycle pulse)
dmem_reqM  in  1  load/store in M requesting memory
dmem_ready  in  1  memory completes access this cycle
StallF, StallD, StallE, StallM  out  1 each  hold stage register
FlushD, FlushE, FlushM  out  1 each  insert bubble into stage register
forwardAE, forwardBE  out  2 each  operand select: 00 = from M, 10 = from W, 01 = register file
mc_timeout  out  1  one-cycle pulse, multi-cycle op abandoned
stall_cycles  out  CNT_W  cycles with StallF=1
flush_count  out  CNT_W  branch-flush events

Behaviour:
- Reset (rst_n=0, async):
  - FSM = RUN; counters = 0; mc_timeout = 0; MC cycle counter = 0.
  - All stall/flush outputs are forced 0 and forwardAE/BE are forced 01 while rst_n=0.
- Forwarding (combinational):
  - rsX valid = raddrXE != 0.
  - Source is M (00) if raddrXE==waddrM & reg_wrM & valid.
  - Else source is W (10) if raddrXE==waddrW & reg_wrW & valid.
  - Else 01.
  - M has priority over W.
  - Forwarding is computed every cycle, including while stalled.
- Stall/flush priority, highest first, all combinational from inputs and FSM state:
  1. Memory wait: dmem_reqM & !dmem_ready.
     - StallF, StallD, StallE, StallM = 1; no flushes.
     - Branch flush is suppressed (the branch is held in E and resolves again).
  2. Multi-cycle wait: FSM=MC_WAIT, or RUN with mc_startE & !mc_done.
     - StallF, StallD, StallE = 1; FlushM = 1 (bubble into M).
     - Deasserted in the same cycle mc_done=1.
  3. Branch: br_takenE.
     - FlushD = FlushE = 1; no stalls.
     - Overrides a load-use hazard detected in the same cycle (the D instruction is wrong-path).
  4. Load-use: wb_selE==2'b10 & reg_wrE & waddrE!=0 & (raddr1D==waddrE | raddr2D==waddrE).
     - StallF = StallD = 1; FlushE = 1.
     - Load-use matches on x0 are ignored (fixes prior false stalls on rd=x0).
- FSM states: RUN, MC_WAIT, MEM_WAIT.
  - RUN -> MEM_WAIT when the memory-wait condition holds; this takes precedence over MC.
  - RUN -> MC_WAIT when mc_startE & !mc_done & no memory wait; MC counter loads 1.
  - MEM_WAIT -> RUN on the cycle dmem_ready=1.
  - MC_WAIT -> RUN on mc_done.
  - MC_WAIT, counter == MC_MAX-1 with no done: mc_timeout pulses 1 cycle, stalls drop that cycle, FSM -> RUN, counter clears.
  - MC_WAIT, otherwise: counter increments.
  - mc_done while in RUN with !mc_startE is ignored.
  - Memory wait arising while in MC_WAIT: all four stalls asserted, MC counter still advances.
- Counters:
  - stall_cycles += 1 each cycle StallF=1.
  - flush_count += 1 each cycle FlushE from a branch.
  - Both saturate at all-ones (no wrap).
  - The MC counter is ceil(log2(MC_MAX)) bits.
- Reset mid-wait returns to RUN immediately; stalls drop asynchronously.

Test Plan:
- Forwarding: raddr1E=5, waddrM=5 reg_wrM=1, waddrW=5 reg_wrW=1 -> forwardAE=00. Then reg_wrM=0 -> 10. Then raddr1E=0 -> 01.
- Load-use: wb_selE=10, reg_wrE=1, waddrE=7, raddr2D=7 -> StallF=StallD=FlushE=1 for exactly 1 cycle, stall_cycles=1. Same with waddrE=0 -> no stall.
- Branch vs load-use: both conditions in the same cycle -> FlushD=FlushE=1, StallF=0, flush_count=1.
- MC op: mc_startE=1, mc_done on 5th cycle -> StallF/D/E=1 and FlushM=1 for 4 cycles, released the cycle mc_done=1, FSM RUN. With MC_MAX=4 and no done -> mc_timeout pulse in the 4th cycle, then RUN.
- Memory wait: dmem_reqM=1, dmem_ready low 3 cycles, with br_takenE=1 -> all four stalls high 3 cycles, no flush. The flush appears on the dmem_ready cycle.
- Saturation/reset: CNT_W=3, stall 10 cycles -> stall_cycles=7. Assert rst_n=0 mid-MC_WAIT -> stalls 0 immediately, counters 0.
